// File: rtl/lsu_pkg.sv
// lsu_pkg: shared pipeline encodings used by the load/store stage and its neighbours.
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [1:0] SZ_B  = 2'b00;
    localparam logic [1:0] SZ_H  = 2'b01;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_OUT} state_t;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: load extract/extend, store lane steering and misalignment check.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  funct3,
    input  logic        mem_op,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] load_data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic        misalign
);
    logic [1:0]  lane;
    logic [31:0] shifted;
    assign lane    = addr[1:0];
    assign shifted = rdata >> {lane, 3'b000};
    // funct3[1:0] encodes the access size; unlisted codes fall into the word size
    assign misalign  = mem_op && (funct3[1:0] == SZ_H ? addr[0] : (funct3[1:0] != SZ_B && lane != 2'b00));
    assign load_data = funct3 == F3_B  ? {{24{shifted[7]}}, shifted[7:0]} :
                       funct3 == F3_H  ? {{16{shifted[15]}}, shifted[15:0]} :
                       funct3 == F3_BU ? {24'b0, shifted[7:0]} :
                       funct3 == F3_HU ? {16'b0, shifted[15:0]} : shifted;
    assign wstrb = funct3[1:0] == SZ_B ? 4'b0001 << lane :
                   funct3[1:0] == SZ_H ? 4'b0011 << lane : 4'b1111;
    assign wdata = funct3[1:0] == SZ_B ? {4{store_data[7:0]}} :
                   funct3[1:0] == SZ_H ? {2{store_data[15:0]}} : store_data;
endmodule

// File: rtl/lsu.sv
// lsu: load/store stage between EXU and WBU; one instruction in flight,
// at most one memory request, write-back bundle held until WBU accepts.
module lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_result,
    input  logic [31:0] in_store_data,
    input  logic        in_mem_ren,
    input  logic        in_mem_wen,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_wen,
    input  logic        in_is_csr,
    input  logic        in_csr_wen,
    input  logic        in_ebreak,
    input  logic        in_ecall,
    input  logic        in_mret,
    input  logic [31:0] in_csr_wdata,
    input  logic [31:0] in_a0_data,
    input  logic [11:0] in_csr_addr,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,
    input  logic        mem_resp_valid,
    output logic        mem_resp_ready,
    input  logic [31:0] mem_resp_rdata,
    input  logic        mem_resp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_reg_wen,
    output logic        out_is_csr,
    output logic        out_csr_wen,
    output logic        out_ebreak,
    output logic        out_ecall,
    output logic        out_mret,
    output logic [31:0] out_csr_wdata,
    output logic [31:0] out_a0_data,
    output logic [11:0] out_csr_addr,
    output logic        misalign,
    output logic        bus_err
);
    state_t      state, state_next;
    logic        idle, accept, resp_fire, mis, is_load;
    logic [31:0] align_addr, load_data, wdata;
    logic [2:0]  align_f3, funct3;
    logic [3:0]  wstrb;
    assign idle       = state == S_IDLE;
    assign accept     = idle && in_valid;
    assign resp_fire  = state == S_RESP && mem_resp_valid;
    // the aligner sees the incoming op while idle and the latched op afterwards
    assign align_addr = idle ? in_result : mem_req_addr;
    assign align_f3   = idle ? in_funct3 : funct3;
    lsu_align u_align (
        .addr       (align_addr),
        .funct3     (align_f3),
        .mem_op     (in_mem_ren | in_mem_wen),
        .store_data (in_store_data),
        .rdata      (mem_resp_rdata),
        .load_data  (load_data),
        .wstrb      (wstrb),
        .wdata      (wdata),
        .misalign   (mis)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end
    always_comb begin
        state_next     = state;
        in_ready       = 1'b0;
        mem_req_valid  = 1'b0;
        mem_resp_ready = 1'b0;
        out_valid      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = (in_mem_ren || in_mem_wen) && !mis ? S_REQ : S_OUT;
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_next = S_RESP;
            end
            S_RESP: begin
                mem_resp_ready = 1'b1;
                if (mem_resp_valid) state_next = S_OUT;
            end
            default: begin
                out_valid = 1'b1;
                if (out_ready) state_next = S_IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {out_pc, out_inst, out_result, out_rd, out_reg_wen, out_is_csr, out_csr_wen} <= '0;
            {out_ebreak, out_ecall, out_mret, out_csr_wdata, out_a0_data, out_csr_addr} <= '0;
            {mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb, funct3, is_load} <= '0;
            misalign <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            if (accept) begin
                {out_pc, out_inst, out_rd, out_is_csr, out_csr_wen} <= {in_pc, in_inst, in_rd, in_is_csr, in_csr_wen};
                {out_ebreak, out_ecall, out_mret} <= {in_ebreak, in_ecall, in_mret};
                {out_csr_wdata, out_a0_data, out_csr_addr} <= {in_csr_wdata, in_a0_data, in_csr_addr};
                out_result    <= mis ? 32'b0 : in_result;
                out_reg_wen   <= in_reg_wen && !mis;
                misalign      <= mis;
                mem_req_addr  <= in_result;
                mem_req_wen   <= in_mem_wen;
                mem_req_wdata <= wdata;
                mem_req_wstrb <= in_mem_wen ? wstrb : 4'b0;
                funct3        <= in_funct3;
                is_load       <= in_mem_ren && !in_mem_wen;
            end else if (resp_fire) begin
                if (mem_resp_err) begin
                    out_result  <= 32'b0;
                    out_reg_wen <= 1'b0;
                    bus_err     <= 1'b1;
                end else if (is_load) begin
                    out_result  <= load_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized and directed checks of lsu against a behavioural model.
module tb_lsu;
    typedef struct packed {
        logic [31:0] pc, inst, result, sdata, csr_wdata, a0;
        logic        ren, wen;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        reg_wen, is_csr, csr_wen, ebreak, ecall, mret;
        logic [11:0] csr_addr;
    } op_t;

    logic clk = 1'b0, rst = 1'b0;
    logic in_valid = 1'b0, in_ready;
    logic [31:0] in_pc = '0, in_inst = '0, in_result = '0, in_store_data = '0, in_csr_wdata = '0, in_a0_data = '0;
    logic in_mem_ren = 1'b0, in_mem_wen = 1'b0, in_reg_wen = 1'b0, in_is_csr = 1'b0, in_csr_wen = 1'b0;
    logic in_ebreak = 1'b0, in_ecall = 1'b0, in_mret = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [4:0]  in_rd = '0;
    logic [11:0] in_csr_addr = '0;
    logic mem_req_valid, mem_req_ready = 1'b0, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic mem_resp_valid = 1'b0, mem_resp_ready, mem_resp_err = 1'b0;
    logic [31:0] mem_resp_rdata = '0;
    logic out_valid, out_ready = 1'b0;
    logic [31:0] out_pc, out_inst, out_result, out_csr_wdata, out_a0_data;
    logic [4:0]  out_rd;
    logic out_reg_wen, out_is_csr, out_csr_wen, out_ebreak, out_ecall, out_mret;
    logic [11:0] out_csr_addr;
    logic misalign, bus_err;
    logic [182:0] out_bundle;

    int vectors = 0, miscompares = 0;
    int out_cyc, mis_cnt, berr_cnt;
    logic req_seen, req_stable, frozen_ok, ir_bad, idle_after, got_reg_wen;
    logic [31:0] got_result;
    logic [182:0] got_bundle;
    logic [68:0] req_snap;

    always #5 clk = ~clk;

    assign out_bundle = {out_pc, out_inst, out_result, out_rd, out_reg_wen, out_is_csr, out_csr_wen,
                         out_ebreak, out_ecall, out_mret, out_csr_wdata, out_a0_data, out_csr_addr};

    lsu dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_result(in_result), .in_store_data(in_store_data),
        .in_mem_ren(in_mem_ren), .in_mem_wen(in_mem_wen), .in_funct3(in_funct3), .in_rd(in_rd),
        .in_reg_wen(in_reg_wen), .in_is_csr(in_is_csr), .in_csr_wen(in_csr_wen), .in_ebreak(in_ebreak),
        .in_ecall(in_ecall), .in_mret(in_mret), .in_csr_wdata(in_csr_wdata), .in_a0_data(in_a0_data),
        .in_csr_addr(in_csr_addr),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_rdata(mem_resp_rdata),
        .mem_resp_err(mem_resp_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_result(out_result), .out_rd(out_rd), .out_reg_wen(out_reg_wen), .out_is_csr(out_is_csr),
        .out_csr_wen(out_csr_wen), .out_ebreak(out_ebreak), .out_ecall(out_ecall), .out_mret(out_mret),
        .out_csr_wdata(out_csr_wdata), .out_a0_data(out_a0_data), .out_csr_addr(out_csr_addr),
        .misalign(misalign), .bus_err(bus_err)
    );

    // ---------------- reference model ----------------
    function automatic int size_of(logic [2:0] f3);
        return f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    endfunction

    function automatic logic [31:0] load_ref(logic [2:0] f3, logic [31:0] addr, logic [31:0] rdata);
        logic [31:0] v;
        v = rdata >> (8 * (addr % 4));
        case (f3)
            3'd0: return (v % 256 >= 128) ? (v % 256) - 256 : v % 256;
            3'd1: return (v % 65536 >= 32768) ? (v % 65536) - 65536 : v % 65536;
            3'd4: return v % 256;
            3'd5: return v % 65536;
            default: return v;
        endcase
    endfunction

    function automatic logic [3:0] strb_ref(logic [2:0] f3, logic [31:0] addr);
        int sz;
        sz = size_of(f3);
        if (sz == 4) return 4'hF;
        return 4'(((1 << sz) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] wdata_ref(logic [2:0] f3, logic [31:0] d);
        int sz;
        sz = size_of(f3);
        if (sz == 1) return (d % 256) * 32'h0101_0101;
        if (sz == 2) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [182:0] bundle_of(op_t op, logic [31:0] res, logic wen);
        return {op.pc, op.inst, res, op.rd, wen, op.is_csr, op.csr_wen, op.ebreak, op.ecall, op.mret,
                op.csr_wdata, op.a0, op.csr_addr};
    endfunction

    function automatic op_t rand_op();
        op_t op;
        op = '0;
        op.pc = $urandom; op.inst = $urandom; op.result = $urandom; op.sdata = $urandom;
        op.csr_wdata = $urandom; op.a0 = $urandom; op.rd = 5'($urandom); op.csr_addr = 12'($urandom);
        op.f3 = 3'($urandom);
        {op.reg_wen, op.is_csr, op.csr_wen, op.ebreak, op.ecall, op.mret} = 6'($urandom);
        return op;
    endfunction

    // ---------------- drivers ----------------
    task automatic drive(input op_t op);
        in_pc = op.pc; in_inst = op.inst; in_result = op.result; in_store_data = op.sdata;
        in_mem_ren = op.ren; in_mem_wen = op.wen; in_funct3 = op.f3; in_rd = op.rd;
        in_reg_wen = op.reg_wen; in_is_csr = op.is_csr; in_csr_wen = op.csr_wen; in_ebreak = op.ebreak;
        in_ecall = op.ecall; in_mret = op.mret; in_csr_wdata = op.csr_wdata; in_a0_data = op.a0;
        in_csr_addr = op.csr_addr;
    endtask

    // Runs one op through the stage acting as memory and WBU; records what was observed.
    task automatic issue(input op_t op, input int req_d, input int resp_d, input int out_d,
                         input logic [31:0] rdata, input logic err);
        int cyc, rq_w, rs_w, o_w;
        logic done;
        cyc = 0; rq_w = 0; rs_w = 0; o_w = 0; done = 1'b0;
        req_seen = 1'b0; req_stable = 1'b1; frozen_ok = 1'b1; ir_bad = 1'b0;
        mis_cnt = 0; berr_cnt = 0; out_cyc = -1; req_snap = '0;
        @(negedge clk);
        drive(op);
        in_valid = 1'b1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            in_valid = 1'b0;
            if (in_ready) ir_bad = 1'b1;
            mis_cnt  += misalign ? 1 : 0;
            berr_cnt += bus_err ? 1 : 0;
            if (mem_req_valid) begin
                if (!req_seen) req_snap = {mem_req_addr, mem_req_wen, mem_req_wstrb, mem_req_wdata};
                else if ({mem_req_addr, mem_req_wen, mem_req_wstrb, mem_req_wdata} !== req_snap) req_stable = 1'b0;
                req_seen = 1'b1;
                mem_req_ready = rq_w >= req_d;
                rq_w++;
            end else mem_req_ready = 1'b0;
            if (mem_resp_ready) begin
                mem_resp_valid = rs_w >= resp_d;
                mem_resp_rdata = rs_w >= resp_d ? rdata : $urandom;
                mem_resp_err   = rs_w >= resp_d ? err : 1'($urandom);
                rs_w++;
            end else mem_resp_valid = 1'b0;
            if (out_valid) begin
                if (out_cyc < 0) begin
                    out_cyc = cyc; got_bundle = out_bundle; got_result = out_result; got_reg_wen = out_reg_wen;
                end else if (out_bundle !== got_bundle) frozen_ok = 1'b0;
                out_ready = o_w >= out_d;
                done = out_ready;
                o_w++;
            end
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL issue_timeout: got no out handshake in %0d cycles, want one", cyc);
        end
        @(negedge clk);
        out_ready = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        mis_cnt  += misalign ? 1 : 0;
        berr_cnt += bus_err ? 1 : 0;
        idle_after = in_ready;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        vectors++;
        if ({in_ready, mem_req_valid, mem_resp_ready, out_valid, misalign, bus_err} !== 6'b100000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b, want 100000",
                     {in_ready, mem_req_valid, mem_resp_ready, out_valid, misalign, bus_err});
        end
        vectors++;
        if ({out_bundle, mem_req_addr, mem_req_wen, mem_req_wstrb, mem_req_wdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got bundle=%h req=%h/%b/%h, want all zero",
                     out_bundle, mem_req_addr, mem_req_wstrb, mem_req_wdata);
        end
    endtask

    task automatic test_alu();
        op_t op;
        op = rand_op(); op.result = 32'h1234;
        issue(op, 0, 0, 0, 32'h0, 1'b0);
        vectors++;
        if (out_cyc !== 1) begin miscompares++; $display("FAIL alu_latency: got %0d, want 1", out_cyc); end
        vectors++;
        if (got_bundle !== bundle_of(op, 32'h1234, op.reg_wen)) begin
            miscompares++; $display("FAIL alu_bundle: got %h, want %h", got_bundle, bundle_of(op, 32'h1234, op.reg_wen));
        end
        vectors++;
        if ({req_seen, ir_bad, idle_after} !== 3'b001) begin
            miscompares++; $display("FAIL alu_handshake: got req/busy_ready/idle=%b, want 001", {req_seen, ir_bad, idle_after});
        end
    endtask

    task automatic test_back_to_back();
        op_t op;
        int lat_ok;
        lat_ok = 1;
        for (int i = 0; i < 3; i++) begin
            op = rand_op();
            issue(op, 0, 0, 0, 32'h0, 1'b0);
            if (out_cyc != 1 || ir_bad || !idle_after || got_result !== op.result) lat_ok = 0;
        end
        vectors++;
        if (lat_ok != 1) begin miscompares++; $display("FAIL back_to_back: got ok=%0d, want 1", lat_ok); end
    endtask

    task automatic test_loads();
        op_t op;
        op = rand_op(); op.ren = 1'b1; op.f3 = 3'b000; op.result = 32'h8000_0003; op.reg_wen = 1'b1;
        issue(op, 0, 0, 0, 32'h80FF_0000, 1'b0);
        vectors++;
        if (got_result !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL lb_result: got %h, want ffffff80", got_result); end
        vectors++;
        if ({req_seen, req_snap[68:37], req_snap[36], req_snap[35:32], out_cyc} !== {1'b1, 32'h8000_0003, 1'b0, 4'b0, 32'd3}) begin
            miscompares++; $display("FAIL lb_request: got seen=%b addr=%h wen=%b strb=%b lat=%0d, want 1 80000003 0 0000 3",
                                    req_seen, req_snap[68:37], req_snap[36], req_snap[35:32], out_cyc);
        end
        op.f3 = 3'b100;
        issue(op, 1, 2, 0, 32'h80FF_0000, 1'b0);
        vectors++;
        if ({got_result, got_reg_wen} !== {32'h0000_0080, 1'b1}) begin
            miscompares++; $display("FAIL lbu_result: got %h wen=%b, want 00000080 1", got_result, got_reg_wen);
        end
    endtask

    task automatic test_store();
        op_t op;
        op = rand_op(); op.wen = 1'b1; op.f3 = 3'b001; op.result = 32'h8000_0002; op.sdata = 32'hABCD_1234; op.reg_wen = 1'b0;
        issue(op, 0, 0, 0, 32'hDEAD_BEEF, 1'b0);
        vectors++;
        if ({req_snap[36], req_snap[35:32], req_snap[31:0]} !== {1'b1, 4'b1100, 32'h1234_1234}) begin
            miscompares++; $display("FAIL sh_request: got wen=%b strb=%b data=%h, want 1 1100 12341234",
                                    req_snap[36], req_snap[35:32], req_snap[31:0]);
        end
        vectors++;
        if ({got_result, got_reg_wen} !== {32'h8000_0002, 1'b0}) begin
            miscompares++; $display("FAIL sh_result: got %h wen=%b, want 80000002 0", got_result, got_reg_wen);
        end
    endtask

    task automatic test_misalign();
        op_t op;
        op = rand_op(); op.ren = 1'b1; op.f3 = 3'b010; op.result = 32'h8000_0001; op.reg_wen = 1'b1;
        issue(op, 0, 0, 0, 32'h0, 1'b0);
        vectors++;
        if ({req_seen, mis_cnt, out_cyc} !== {1'b0, 32'd1, 32'd1}) begin
            miscompares++; $display("FAIL lw_misalign: got req=%b pulses=%0d lat=%0d, want 0 1 1", req_seen, mis_cnt, out_cyc);
        end
        vectors++;
        if ({got_result, got_reg_wen} !== 33'h0) begin
            miscompares++; $display("FAIL lw_misalign_result: got %h wen=%b, want 0 0", got_result, got_reg_wen);
        end
    endtask

    task automatic test_backpressure_err();
        op_t op;
        op = rand_op(); op.ren = 1'b1; op.f3 = 3'b010; op.result = 32'h8000_0100; op.reg_wen = 1'b1;
        issue(op, 5, 0, 3, 32'h1111_2222, 1'b1);
        vectors++;
        if ({req_stable, frozen_ok, berr_cnt, out_cyc} !== {1'b1, 1'b1, 32'd1, 32'd8}) begin
            miscompares++; $display("FAIL bp_err: got stable=%b frozen=%b pulses=%0d lat=%0d, want 1 1 1 8",
                                    req_stable, frozen_ok, berr_cnt, out_cyc);
        end
        vectors++;
        if ({got_result, got_reg_wen} !== 33'h0) begin
            miscompares++; $display("FAIL bp_err_result: got %h wen=%b, want 0 0", got_result, got_reg_wen);
        end
    endtask

    task automatic test_reset_mid();
        op_t op;
        int n;
        logic ok;
        op = rand_op(); op.ren = 1'b1; op.f3 = 3'b010; op.result = 32'h8000_0010;
        @(negedge clk);
        drive(op);
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            mem_req_ready = mem_req_valid;
            n++;
        end while (!mem_resp_ready && n < 20);
        mem_req_ready = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({mem_resp_ready, out_valid} !== 2'b10) begin
            miscompares++; $display("FAIL mid_in_resp: got resp_ready/out_valid=%b, want 10", {mem_resp_ready, out_valid});
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, mem_req_valid, mem_resp_ready, out_result} !== {4'b1000, 32'h0}) begin
            miscompares++; $display("FAIL mid_reset: got rdy/ov/rv/rr=%b res=%h, want 1000 0",
                                    {in_ready, out_valid, mem_req_valid, mem_resp_ready}, out_result);
        end
        @(negedge clk);
        rst = 1'b1;
        mem_resp_valid = 1'b1; mem_resp_rdata = $urandom; mem_resp_err = 1'b0;
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || mem_resp_ready !== 1'b0) ok = 1'b0;
        end
        mem_resp_valid = 1'b0;
        vectors++;
        if (ok !== 1'b1) begin miscompares++; $display("FAIL stale_resp: got ok=%b, want 1", ok); end
    endtask

    task automatic test_random();
        logic [2:0] lf3 [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
        op_t op;
        int kind, req_d, resp_d, out_d, sz, lat;
        logic [31:0] rdata, res;
        logic err, mis, req, berr, rwen;
        for (int i = 0; i < 60; i++) begin
            op = rand_op();
            kind = $urandom_range(0, 2);
            if (kind == 1) begin op.ren = 1'b1; op.f3 = lf3[$urandom_range(0, 6)]; end
            if (kind == 2) begin op.wen = 1'b1; op.f3 = 3'($urandom_range(0, 2)); end
            req_d = $urandom_range(0, 3); resp_d = $urandom_range(0, 3); out_d = $urandom_range(0, 3);
            rdata = $urandom; err = $urandom_range(0, 7) == 0;
            sz   = size_of(op.f3);
            mis  = (op.ren || op.wen) && (op.result % sz != 0);
            req  = (op.ren || op.wen) && !mis;
            berr = req && err;
            res  = (mis || berr) ? 32'h0 : op.ren ? load_ref(op.f3, op.result, rdata) : op.result;
            rwen = op.reg_wen && !mis && !berr;
            lat  = req ? req_d + resp_d + 3 : 1;
            issue(op, req_d, resp_d, out_d, rdata, err);
            vectors++;
            if (got_bundle !== bundle_of(op, res, rwen)) begin
                miscompares++; $display("FAIL rand_bundle[%0d]: got %h, want %h", i, got_bundle, bundle_of(op, res, rwen));
            end
            vectors++;
            if ({req_seen, mis_cnt, berr_cnt, out_cyc} !== {req, mis ? 32'd1 : 32'd0, berr ? 32'd1 : 32'd0, lat}) begin
                miscompares++; $display("FAIL rand_flow[%0d]: got req=%b mis=%0d berr=%0d lat=%0d, want %b %0d %0d %0d",
                                        i, req_seen, mis_cnt, berr_cnt, out_cyc, req, mis, berr, lat);
            end
            vectors++;
            if ({req_stable, frozen_ok, ir_bad, idle_after} !== 4'b1101) begin
                miscompares++; $display("FAIL rand_hold[%0d]: got stable/frozen/busy_ready/idle=%b, want 1101",
                                        i, {req_stable, frozen_ok, ir_bad, idle_after});
            end
            if (req) begin
                vectors++;
                if ({req_snap[68:37], req_snap[36], req_snap[35:32]} !== {op.result, op.wen, op.wen ? strb_ref(op.f3, op.result) : 4'b0}) begin
                    miscompares++; $display("FAIL rand_req[%0d]: got addr=%h wen=%b strb=%b, want %h %b %b", i,
                                            req_snap[68:37], req_snap[36], req_snap[35:32], op.result, op.wen,
                                            op.wen ? strb_ref(op.f3, op.result) : 4'b0);
                end
                if (op.wen) begin
                    vectors++;
                    if (req_snap[31:0] !== wdata_ref(op.f3, op.sdata)) begin
                        miscompares++; $display("FAIL rand_wdata[%0d]: got %h, want %h", i, req_snap[31:0], wdata_ref(op.f3, op.sdata));
                    end
                end
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b1;
        test_alu();
        test_back_to_back();
        test_loads();
        test_store();
        test_misalign();
        test_backpressure_err();
        test_reset_mid();
        test_alu();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lsu.md
# lsu

Load/store stage of the multi-cycle pipeline, between EXU and WBU. Accepts one instruction at a time from EXU and issues at most one memory request for a load or store. Formats load data, then presents the full write-back bundle to WBU over a valid/ready handshake. Non-memory instructions pass through with one register stage.

## Interface
- No parameters; the datapath is fixed at 32 bits.

Clock and reset:
- `clk  input  1`  — single clock.
- `rst  input  1`  — asynchronous, active-low reset.

Upstream (from EXU):
- `in_valid  input  1`
- `in_ready  output  1`
- `in_pc, in_inst  input  32`
- `in_result  input  32`  — ALU result; this is the address for loads and stores.
- `in_store_data  input  32`  — rs2 value.
- `in_mem_ren, in_mem_wen  input  1`
- `in_funct3  input  3`  — access size and sign.
- `in_rd  input  5`
- `in_reg_wen, in_is_csr, in_csr_wen, in_ebreak, in_ecall, in_mret  input  1`
- `in_csr_wdata, in_a0_data  input  32`
- `in_csr_addr  input  12`

Memory request:
- `mem_req_valid  output  1`
- `mem_req_ready  input  1`
- `mem_req_addr  output  32`  — byte address, unmodified.
- `mem_req_wen  output  1`
- `mem_req_wdata  output  32`  — lane-shifted.
- `mem_req_wstrb  output  4`

Memory response:
- `mem_resp_valid  input  1`
- `mem_resp_ready  output  1`
- `mem_resp_rdata  input  32`
- `mem_resp_err  input  1`

Downstream (to WBU):
- `out_valid  output  1`
- `out_ready  input  1`
- `out_*  output`  — same names and widths as every `in_*` sideband field above, except `in_store_data`, `in_mem_ren`, `in_mem_wen` and `in_funct3`, which are not forwarded.
- `out_result  output  32`  — load data or passed-through ALU result.

Status:
- `misalign  output  1`  — one-cycle pulse.
- `bus_err  output  1`  — one-cycle pulse.

## Operation
- States: `S_IDLE`, `S_REQ`, `S_RESP`, `S_OUT`. Reset state is `S_IDLE`.
- `S_IDLE`:
  - `in_ready`=1.
  - On `in_valid`, latch every `in_*` field.
  - Memory op and aligned → `S_REQ`. Otherwise → `S_OUT`.
- Misalignment rules:
  - Halfword with `addr[0]`=1 is misaligned.
  - Word with `addr[1:0]`≠0 is misaligned.
  - Misaligned op: no request is issued, `out_reg_wen` is forced to 0, `out_result` is 0, and `misalign` pulses on entry to `S_OUT`.
- `S_REQ`:
  - `mem_req_valid`=1, with address, wen, wdata and wstrb held stable.
  - On `mem_req_ready` → `S_RESP`.
- `S_RESP`:
  - `mem_resp_ready`=1.
  - On `mem_resp_valid`, register formatted data → `S_OUT`.
  - If `mem_resp_err`: `out_result` is 0, `out_reg_wen` is forced to 0, and `bus_err` pulses.
- `S_OUT`:
  - `out_valid`=1, all outputs stable.
  - On `out_ready` → `S_IDLE`.
- Load formatting, with lane = `addr[1:0]` and data = `rdata >> (8*lane)`:
  - funct3 000: LB, sign-extend bit 7.
  - 001: LH, sign-extend bit 15.
  - 010: LW.
  - 100: LBU, zero-extend.
  - 101: LHU, zero-extend.
  - Other funct3 values are treated as LW.
- Store encoding, by funct3:
  - SB: `wstrb`=0001<<lane, `wdata`={4{rs2[7:0]}}.
  - SH: `wstrb`=0011<<lane, `wdata`={2{rs2[15:0]}}.
  - SW: `wstrb`=1111, `wdata`=rs2.
- Stores: `out_result` keeps `in_result`. The response data is ignored.
- Non-memory ops: all fields pass through unchanged.

## Timing
- Reset values:
  - `in_ready`=1.
  - `mem_req_valid`, `mem_resp_ready`, `out_valid`, `misalign`, `bus_err` = 0.
  - All latched data outputs = 0.
- Non-memory latency: accept in cycle N, `out_valid` in N+1.
- Memory latency: request in N+1; response handshake in cycle R; `out_valid` in R+1.
- No bypass. `in_ready` is 0 in every state except `S_IDLE`. After an `S_OUT` handshake the next accept is one cycle later, so non-memory throughput is one instruction per 2 cycles.
- `mem_req_valid` is never deasserted before `mem_req_ready`. The request fields are unchanged while waiting.
- `mem_resp_valid` outside `S_RESP` is ignored.
- Reset mid-operation: any outstanding request or response is abandoned and the block returns to `S_IDLE`. A stale response arriving after reset is ignored.
- `out_valid` stays high and outputs are frozen until `out_ready`. This holds under arbitrary backpressure.

## Structure
- Shared pipeline package holds the funct3 load/store encodings, the state localparams and the CSR address constants used with WBU.
- Sub-module `lsu_align`: combinational; produces load extract/sign-extend, store wstrb/wdata generation and the misalign check.
- `lsu` itself contains the FSM and the bundle registers.

## Test plan
- ADD result 0x1234, out_ready=1 → out_valid in cycle N+1, out_result=0x1234, no mem_req.
- LB at 0x80000003, rdata=0x80FF_0000 → out_result=0xFFFFFF80. LBU at the same address and data → 0x00000080.
- SH at 0x80000002, rs2=0xABCD1234 → wstrb=1100, wdata=0x12341234, out_reg_wen=0.
- LW at 0x80000001 → no mem_req, misalign pulse, out_reg_wen=0, out_result=0.
- mem_req_ready held 0 for 5 cycles, then resp with err=1 → req fields stable throughout, bus_err pulse, out_result=0.
- out_ready=0 for 3 cycles, then rst asserted while in `S_RESP` → outputs frozen during backpressure; after reset in_ready=1, out_valid=0, and a late mem_resp_valid is ignored.
